// File: rtl/lock_key_sweep_checker_if.sv
// Handshake/bus bundle between the key-sweep checker and its host/netlist pair.
//   start, abort      : host controls
//   pat_out, key_out  : stimulus to the golden/locked netlists
//   gold_in, lock_in  : netlist responses
//   busy .. first_key : status, per-key reports and sweep summary
interface lock_key_sweep_checker_if #(
    parameter int unsigned IN_W  = 36,
    parameter int unsigned OUT_W = 7,
    parameter int unsigned KEY_W = 3,
    parameter int unsigned N_PAT = 256
);
    localparam int unsigned ERR_W = $clog2(N_PAT + 1);

    logic             start;
    logic             abort;
    logic [IN_W-1:0]  pat_out;
    logic [KEY_W-1:0] key_out;
    logic [OUT_W-1:0] gold_in;
    logic [OUT_W-1:0] lock_in;
    logic             busy;
    logic             res_valid;
    logic [KEY_W-1:0] res_key;
    logic [ERR_W-1:0] res_errs;
    logic             done;
    logic [KEY_W:0]   match_cnt;
    logic             match_found;
    logic [KEY_W-1:0] first_key;

    // Host side: controls the sweep and closes the loop through the netlists.
    modport master (
        output start, abort, gold_in, lock_in,
        input  pat_out, key_out, busy, res_valid, res_key, res_errs,
               done, match_cnt, match_found, first_key
    );

    // Checker side.
    modport slave (
        input  start, abort, gold_in, lock_in,
        output pat_out, key_out, busy, res_valid, res_key, res_errs,
               done, match_cnt, match_found, first_key
    );
endinterface

// File: rtl/lock_key_sweep_checker.sv
// Sweeps every key of a logic-locked netlist against its golden twin, applying the
// same LFSR pattern sequence per key, and reports per-key mismatch counts plus a
// summary of the keys that never mismatched.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lock_key_sweep_checker_if.slave (controls, stimulus, responses, results)
module lock_key_sweep_checker #(
    parameter int unsigned IN_W   = 36,
    parameter int unsigned OUT_W  = 7,
    parameter int unsigned KEY_W  = 3,
    parameter int unsigned N_PAT  = 256,
    parameter int unsigned SETTLE = 2,
    parameter logic [63:0] SEED   = 64'h0123456789ABCDEF
) (
    input logic                      clk,
    input logic                      rst,
    lock_key_sweep_checker_if.slave  bus
);
    localparam int unsigned ERR_W     = $clog2(N_PAT + 1);
    localparam int unsigned PAT_W     = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int unsigned HOLD_W    = (SETTLE > 2) ? $clog2(SETTLE - 1) : 1;
    localparam int unsigned HOLD_LAST = (SETTLE > 1) ? SETTLE - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HOLD, S_CMP, S_REPORT, S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        lfsr_q, lfsr_d;
    logic [KEY_W:0]     key_q, key_d;
    logic [KEY_W-1:0]   key_out_q, key_out_d;
    logic [PAT_W-1:0]   pat_idx_q, pat_idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0]   err_q, err_d, err_n;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic [KEY_W-1:0]   res_key_q, res_key_d;
    logic [ERR_W-1:0]   res_errs_q, res_errs_d;
    logic               done_q, done_d;
    logic [KEY_W:0]     match_cnt_q, match_cnt_d;
    logic               match_found_q, match_found_d;
    logic [KEY_W-1:0]   first_key_q, first_key_d;

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        key_d         = key_q;
        key_out_d     = key_out_q;
        pat_idx_d     = pat_idx_q;
        hold_d        = hold_q;
        err_d         = err_q;
        res_valid_d   = 1'b0;
        res_key_d     = res_key_q;
        res_errs_d    = res_errs_q;
        done_d        = 1'b0;
        match_cnt_d   = match_cnt_q;
        match_found_d = match_found_q;
        first_key_d   = first_key_q;
        err_n         = err_q + ERR_W'(bus.gold_in != bus.lock_in);

        if (bus.abort) begin
            // Abort wins: drop to IDLE, no partial report, summary untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        key_d         = '0;
                        match_cnt_d   = '0;
                        match_found_d = 1'b0;
                        first_key_d   = '0;
                        state_d       = S_SETUP;
                    end
                end
                S_SETUP: begin
                    lfsr_d    = SEED;
                    pat_idx_d = '0;
                    err_d     = '0;
                    hold_d    = '0;
                    key_out_d = key_q[KEY_W-1:0];
                    state_d   = (SETTLE > 1) ? S_HOLD : S_CMP;
                end
                S_HOLD: begin
                    if (hold_q == HOLD_W'(HOLD_LAST)) begin
                        state_d = S_CMP;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                S_CMP: begin
                    err_d = err_n;
                    if (pat_idx_q == PAT_W'(N_PAT - 1)) begin
                        // Report and summary update become visible together in REPORT.
                        state_d     = S_REPORT;
                        res_valid_d = 1'b1;
                        res_key_d   = key_out_q;
                        res_errs_d  = err_n;
                        if (err_n == '0) begin
                            match_cnt_d = match_cnt_q + (KEY_W+1)'(1);
                            if (!match_found_q) begin
                                match_found_d = 1'b1;
                                first_key_d   = key_out_q;
                            end
                        end
                    end else begin
                        lfsr_d    = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
                        pat_idx_d = pat_idx_q + PAT_W'(1);
                        hold_d    = '0;
                        state_d   = (SETTLE > 1) ? S_HOLD : S_CMP;
                    end
                end
                S_REPORT: begin
                    if (key_q == (KEY_W+1)'((1 << KEY_W) - 1)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = key_q + (KEY_W+1)'(1);
                        state_d = S_SETUP;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lfsr_q        <= '0;
            key_q         <= '0;
            key_out_q     <= '0;
            pat_idx_q     <= '0;
            hold_q        <= '0;
            err_q         <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_key_q     <= '0;
            res_errs_q    <= '0;
            done_q        <= 1'b0;
            match_cnt_q   <= '0;
            match_found_q <= 1'b0;
            first_key_q   <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            key_q         <= key_d;
            key_out_q     <= key_out_d;
            pat_idx_q     <= pat_idx_d;
            hold_q        <= hold_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            res_key_q     <= res_key_d;
            res_errs_q    <= res_errs_d;
            done_q        <= done_d;
            match_cnt_q   <= match_cnt_d;
            match_found_q <= match_found_d;
            first_key_q   <= first_key_d;
        end
    end

    assign bus.pat_out     = lfsr_q[IN_W-1:0];
    assign bus.key_out     = key_out_q;
    assign bus.busy        = busy_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_key     = res_key_q;
    assign bus.res_errs    = res_errs_q;
    assign bus.done        = done_q;
    assign bus.match_cnt   = match_cnt_q;
    assign bus.match_found = match_found_q;
    assign bus.first_key   = first_key_q;
endmodule
